// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: issues read bursts from the 64x8 FIFO while it sits above its
// almost-empty mark and streams the captured words through a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int BURST_LEN = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_fifo_empty,
  input  logic        i_fifo_full,
  input  logic [7:0]  i_fifo_data,
  output logic        o_fifo_rd_en,
  output logic [7:0]  o_data_out,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  output logic        o_busy,
  output logic        o_overflow_warn,
  output logic [15:0] o_word_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BURST  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [4:0] BURST_LOAD = 5'(BURST_LEN);

  logic [1:0]  r_state;
  logic [4:0]  r_rd_left;
  logic        r_inflight;
  logic [1:0]  r_occ;
  logic [7:0]  r_buf0;
  logic [7:0]  r_buf1;
  logic        r_overflow_warn;
  logic [15:0] r_word_count;

  logic        w_pop;
  logic        w_rd_en;
  logic [2:0]  w_level;

  assign w_pop = (r_occ != 2'd0) & i_data_ready;

  // Read gate: a read may issue only if the buffer slot it will land in is free.
  always_comb begin
    w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    if ((r_state == S_BURST) && (r_rd_left != 5'd0) && (w_level < 3'd2)) begin
      w_rd_en = 1'b1;
    end else begin
      w_rd_en = 1'b0;
    end
  end

  // Burst sequencer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_rd_left <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable && !i_fifo_empty) begin
            r_state   <= S_BURST;
            r_rd_left <= BURST_LOAD;
          end
        end
        S_BURST: begin
          if (w_rd_en) begin
            r_rd_left <= r_rd_left - 5'd1;
            if (r_rd_left == 5'd1) begin
              r_state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Skid buffer: r_buf0 is the head; capture of the in-flight SRAM word goes to the tail.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_buf0     <= 8'h00;
      r_buf1     <= 8'h00;
    end else begin
      r_inflight <= w_rd_en;
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= i_fifo_data;
          end else begin
            r_buf1 <= i_fifo_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= i_fifo_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Status: full-flag echo and delivered-word counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow_warn <= 1'b0;
      r_word_count    <= 16'h0000;
    end else begin
      r_overflow_warn <= i_fifo_full;
      if (w_pop) begin
        r_word_count <= r_word_count + 16'h0001;
      end
    end
  end

  assign o_fifo_rd_en    = w_rd_en;
  assign o_data_out      = r_buf0;
  assign o_data_valid    = (r_occ != 2'd0);
  assign o_busy          = (r_state != S_IDLE);
  assign o_overflow_warn = r_overflow_warn;
  assign o_word_count    = r_word_count;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a behavioural FIFO feeds the DUT and a
// scoreboard queue holds every word read so delivered words can be checked in order.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_fifo_empty = 1'b1;
  logic        i_fifo_full = 1'b0;
  logic [7:0]  i_fifo_data = 8'h00;
  logic        i_data_ready = 1'b0;
  logic        o_fifo_rd_en;
  logic [7:0]  o_data_out;
  logic        o_data_valid;
  logic        o_busy;
  logic        o_overflow_warn;
  logic [15:0] o_word_count;

  always #5 clk = ~clk;

  fifo_burst_reader #(.BURST_LEN(16)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_fifo_empty   (i_fifo_empty),
    .i_fifo_full    (i_fifo_full),
    .i_fifo_data    (i_fifo_data),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .o_data_out     (o_data_out),
    .o_data_valid   (o_data_valid),
    .i_data_ready   (i_data_ready),
    .o_busy         (o_busy),
    .o_overflow_warn(o_overflow_warn),
    .o_word_count   (o_word_count)
  );

  logic [7:0]  mem [0:255];
  int          rd_ptr;
  int          wr_ptr;
  logic [7:0]  sb [$];
  logic [15:0] wc_exp;
  int          n_vec;
  int          n_mis;
  int          rd_cycles;
  int          cyc;
  int          first_rd;
  int          last_rd;
  int          first_vld;
  int          base;
  logic        busy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags();
    i_fifo_empty = ((wr_ptr - rd_ptr) <= 16);
    i_fifo_full  = ((wr_ptr - rd_ptr) >= 48);
  endtask

  task automatic load(input int n);
    rd_ptr = 0;
    wr_ptr = n;
    for (int i = 0; i < n; i++) mem[i] = 8'(i);
    set_flags();
    rd_cycles = 0;
    first_rd  = -1;
    last_rd   = -1;
    first_vld = -1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"},      32'(o_fifo_rd_en),    32'd0);
    check({tag, "_valid"},      32'(o_data_valid),    32'd0);
    check({tag, "_data_out"},   32'(o_data_out),      32'd0);
    check({tag, "_busy"},       32'(o_busy),          32'd0);
    check({tag, "_warn"},       32'(o_overflow_warn), 32'd0);
    check({tag, "_word_count"}, 32'(o_word_count),    32'd0);
  endtask

  // One clock: sample at the falling edge, then model the FIFO just after the rising edge.
  task automatic step();
    logic       rd;
    logic       vld;
    logic [7:0] dout;
    logic       full_s;
    logic       rst_s;
    @(negedge clk);
    rd    = o_fifo_rd_en;
    vld   = o_data_valid;
    dout  = o_data_out;
    full_s = i_fifo_full;
    rst_s = i_reset;
    if (vld) begin
      if (first_vld < 0) first_vld = cyc;
      if (sb.size() == 0) begin
        check("valid_without_read", 32'(vld), 32'd0);
      end else begin
        check("head_word", 32'(dout), 32'(sb[0]));
        if (i_data_ready) begin
          void'(sb.pop_front());
          wc_exp++;
        end
      end
    end
    if (rd) begin
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      rd_cycles++;
      sb.push_back(mem[rd_ptr]);
    end
    check("occ_plus_inflight_le2", 32'(sb.size() <= 2), 32'd1);
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      i_fifo_data = mem[rd_ptr];
      rd_ptr++;
    end
    set_flags();
    if (!rst_s && !i_reset) check("overflow_warn", 32'(o_overflow_warn), 32'(full_s));
    check("word_count", 32'(o_word_count), 32'(wc_exp));
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    wc_exp = 16'h0000;
    cyc = 0;
    load(0);

    // Power-on reset.
    #12;
    check_reset_values("por");
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    step();

    // Reset asserted after five reads of a burst.
    load(20);
    i_data_ready = 1'b1;
    i_enable = 1'b1;
    for (int k = 0; k < 40 && rd_cycles < 5; k++) step();
    check("reach_5_reads", 32'(rd_cycles), 32'd5);
    i_reset = 1'b1;
    i_enable = 1'b0;
    #1;
    check_reset_values("midburst");
    sb.delete();
    wc_exp = 16'h0000;
    step();
    step();
    i_reset = 1'b0;
    repeat (10) step();
    check("no_capture_after_reset", 32'(o_data_valid), 32'd0);
    check("idle_after_reset", 32'(o_busy), 32'd0);

    // Basic burst of 16 from 20 words.
    load(20);
    i_data_ready = 1'b1;
    i_enable = 1'b1;
    base = cyc;
    repeat (40) step();
    check("basic_reads", 32'(rd_cycles), 32'd16);
    check("basic_back_to_back", 32'(last_rd - first_rd), 32'd15);
    check("basic_first_read_cycle", 32'(first_rd - base), 32'd1);
    check("basic_first_word_latency", 32'(first_vld - first_rd), 32'd2);
    check("basic_word_count", 32'(o_word_count), 32'd16);
    check("basic_idle", 32'(o_busy), 32'd0);
    check("basic_drained", 32'(sb.size()), 32'd0);

    // Almost-empty gate: 16 words must never start a burst.
    load(16);
    busy_seen = 1'b0;
    repeat (50) begin
      step();
      if (o_busy) busy_seen = 1'b1;
    end
    check("gate_reads", 32'(rd_cycles), 32'd0);
    check("gate_busy", 32'(busy_seen), 32'd0);

    // Backpressure with ready toggling 1-0-0-1; 33 words give two full bursts.
    load(33);
    for (int k = 0; k < 160; k++) begin
      i_data_ready = ((k % 4) == 0) || ((k % 4) == 3);
      step();
    end
    i_data_ready = 1'b1;
    repeat (10) step();
    check("bp_reads", 32'(rd_cycles), 32'd32);
    check("bp_word_count", 32'(o_word_count), 32'd48);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Almost-full flag echo; 50 words drain through three bursts.
    load(50);
    step();
    check("warn_high", 32'(o_overflow_warn), 32'd1);
    repeat (80) step();
    check("warn_low", 32'(o_overflow_warn), 32'd0);
    check("full_reads", 32'(rd_cycles), 32'd48);
    check("full_word_count", 32'(o_word_count), 32'd96);

    // Counter wrap from 16'hFFFE through three deliveries.
    i_enable = 1'b0;
    step();
    force dut.r_word_count = 16'hFFFE;
    wc_exp = 16'hFFFE;
    step();
    release dut.r_word_count;
    load(20);
    i_enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      i_data_ready = (wc_exp != 16'h0001);
      step();
    end
    check("wrap_word_count", 32'(o_word_count), 32'h0001);
    i_enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
